// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Handshaked ALU placed between issue and writeback. Single-cycle ops
//   (add/sub/logic/shift/compare) are computed from the live inputs at accept
//   and registered, so the result appears one cycle later. MUL/DIVU/REMU
//   capture their operands and run WIDTH iterations of shift-add or
//   restoring division before the result is presented.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (op, operand_a, operand_b)
//   out_valid / out_ready result handshake (result, flags, err)
//   zero/neg/carry/ovf    status flags of the presented result
//   err                   divide by zero, or MUL/DIV when ENABLE_MULDIV=0
//   busy                  high while an iterative op is running
// ---------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLTU = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_NE   = 4'hB;
    localparam logic [3:0] OP_SGEU = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_DIVU = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r,  state_nxt_s;
    logic [3:0]         op_r,     op_nxt_s;
    logic [WIDTH-1:0]   a_r,      a_nxt_s;
    logic [WIDTH-1:0]   b_r,      b_nxt_s;
    logic [WIDTH-1:0]   acc_r,    acc_nxt_s;
    logic [SHW-1:0]     cnt_r,    cnt_nxt_s;
    logic [WIDTH-1:0]   result_r, result_nxt_s;
    logic               zero_r, neg_r, carry_r, ovf_r, err_r, valid_r, busy_r;
    logic               zero_nxt_s, neg_nxt_s, carry_nxt_s, ovf_nxt_s, err_nxt_s;

    logic               accept_s;
    logic               is_muldiv_s;
    logic [SHW-1:0]     sh_s;
    logic [WIDTH:0]     sum_s, dif_s;
    logic [WIDTH-1:0]   sc_res_s;
    logic               sc_carry_s, sc_ovf_s;
    logic [WIDTH:0]     rem_sh_s, rem_dif_s;
    logic               rem_ge_s;
    logic [WIDTH-1:0]   acc_it_s, a_it_s, b_it_s, fin_res_s;
    logic               fin_err_s;

    assign in_ready    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign is_muldiv_s = (op >= OP_MUL);
    assign sh_s        = operand_b[SHW-1:0];

    assign out_valid  = valid_r;
    assign busy       = busy_r;
    assign result     = result_r;
    assign zero_flag  = zero_r;
    assign neg_flag   = neg_r;
    assign carry_flag = carry_r;
    assign ovf_flag   = ovf_r;
    assign err        = err_r;

    // Single-cycle result and ADD/SUB carry/overflow from the live request.
    always_comb begin
        sc_res_s   = {WIDTH{1'b0}};
        sc_carry_s = 1'b0;
        sc_ovf_s   = 1'b0;
        sum_s      = {1'b0, operand_a} + {1'b0, operand_b};
        dif_s      = {1'b0, operand_a} - {1'b0, operand_b};
        case (op)
            OP_ADD: begin
                sc_res_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
                sc_ovf_s   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                             (sum_s[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s   = dif_s[WIDTH-1:0];
                sc_carry_s = dif_s[WIDTH];   // borrow: a < b unsigned
                sc_ovf_s   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                             (dif_s[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_AND:  sc_res_s = operand_a & operand_b;
            OP_OR:   sc_res_s = operand_a | operand_b;
            OP_XOR:  sc_res_s = operand_a ^ operand_b;
            OP_SLL:  sc_res_s = operand_a << sh_s;
            OP_SRL:  sc_res_s = operand_a >> sh_s;
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_SRA:  sc_res_s = $signed(operand_a) >>> sh_s;
            OP_EQ:   sc_res_s = {{(WIDTH-1){1'b0}}, (operand_a == operand_b)};
            OP_NE:   sc_res_s = {{(WIDTH-1){1'b0}}, (operand_a != operand_b)};
            OP_SGEU: sc_res_s = {{(WIDTH-1){1'b0}}, (operand_a >= operand_b)};
            default: sc_res_s = {WIDTH{1'b0}};   // MUL/DIVU/REMU give a zero result on this path
        endcase
    end

    // One iteration of shift-add multiply or restoring divide. For division
    // a_r holds the dividend shifting out / quotient shifting in, acc_r the
    // remainder. A zero divisor naturally yields all-ones quotient and a
    // remainder equal to the dividend.
    always_comb begin
        rem_sh_s  = {acc_r, a_r[WIDTH-1]};
        rem_dif_s = rem_sh_s - {1'b0, b_r};
        rem_ge_s  = ~rem_dif_s[WIDTH];
        if (op_r == OP_MUL) begin
            acc_it_s = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
            a_it_s   = {a_r[WIDTH-2:0], 1'b0};
            b_it_s   = {1'b0, b_r[WIDTH-1:1]};
        end else begin
            acc_it_s = rem_ge_s ? rem_dif_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
            a_it_s   = {a_r[WIDTH-2:0], rem_ge_s};
            b_it_s   = b_r;
        end
        case (op_r)
            OP_MUL:  fin_res_s = acc_it_s;
            OP_DIVU: fin_res_s = a_it_s;
            default: fin_res_s = acc_it_s;
        endcase
        fin_err_s = (op_r != OP_MUL) && (b_r == {WIDTH{1'b0}});
    end

    // Next-state, datapath load/iterate and result/flag update.
    always_comb begin
        state_nxt_s  = state_r;
        op_nxt_s     = op_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        result_nxt_s = result_r;
        zero_nxt_s   = zero_r;
        neg_nxt_s    = neg_r;
        carry_nxt_s  = carry_r;
        ovf_nxt_s    = ovf_r;
        err_nxt_s    = err_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (is_muldiv_s && ENABLE_MULDIV) begin
                        state_nxt_s = ST_BUSY;
                        op_nxt_s    = op;
                        a_nxt_s     = operand_a;
                        b_nxt_s     = operand_b;
                        acc_nxt_s   = {WIDTH{1'b0}};
                        cnt_nxt_s   = {SHW{1'b0}};
                    end else begin
                        state_nxt_s  = ST_DONE;
                        result_nxt_s = sc_res_s;
                        zero_nxt_s   = (sc_res_s == {WIDTH{1'b0}});
                        neg_nxt_s    = sc_res_s[WIDTH-1];
                        carry_nxt_s  = sc_carry_s;
                        ovf_nxt_s    = sc_ovf_s;
                        err_nxt_s    = is_muldiv_s;
                    end
                end else if ((state_r == ST_DONE) && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BUSY: begin
                a_nxt_s   = a_it_s;
                b_nxt_s   = b_it_s;
                acc_nxt_s = acc_it_s;
                cnt_nxt_s = cnt_r + {{(SHW-1){1'b0}}, 1'b1};
                // Last iteration writes the result directly so BUSY lasts WIDTH cycles.
                if (cnt_r == SHW'(WIDTH - 1)) begin
                    state_nxt_s  = ST_DONE;
                    result_nxt_s = fin_res_s;
                    zero_nxt_s   = (fin_res_s == {WIDTH{1'b0}});
                    neg_nxt_s    = fin_res_s[WIDTH-1];
                    carry_nxt_s  = 1'b0;
                    ovf_nxt_s    = 1'b0;
                    err_nxt_s    = fin_err_s;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= 4'h0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            op_r     <= op_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            acc_r    <= acc_nxt_s;
            cnt_r    <= cnt_nxt_s;
            result_r <= result_nxt_s;
            zero_r   <= zero_nxt_s;
            neg_r    <= neg_nxt_s;
            carry_r  <= carry_nxt_s;
            ovf_r    <= ovf_nxt_s;
            err_r    <= err_nxt_s;
            valid_r  <= (state_nxt_s == ST_DONE);
            busy_r   <= (state_nxt_s == ST_BUSY);
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
//   Directed bench for alu_seq_unit (WIDTH=32, ENABLE_MULDIV=1). Expected
//   values are hand-computed constants; each check is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero_flag, neg_flag, carry_flag, ovf_flag, err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .carry_flag(carry_flag), .ovf_flag(ovf_flag), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accept cycle; returns just after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Single-cycle op: result must be present right after the accept edge.
    task automatic run_sc(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags);  // {zero,neg,carry,ovf}
        issue(o, a, b);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".res"}, result, exp_res);
        check({tag, ".flags"}, {28'd0, zero_flag, neg_flag, carry_flag, ovf_flag}, {28'd0, exp_flags});
        check({tag, ".err"}, {31'd0, err}, 32'd0);
        drain();
    endtask

    // Iterative op: counts edges from the accept edge until out_valid.
    task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
        int lat;
        issue(o, a, b);
        lat = 1;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, 32'd33);
        check({tag, ".res"}, result, exp_res);
        check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (3) tick();
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.flags", {27'd0, zero_flag, neg_flag, carry_flag, ovf_flag, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD wrap: zero and carry set
        run_sc("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);

        // SUB signed overflow, plus capture check: inputs changed after accept
        issue(4'h1, 32'h8000_0000, 32'h0000_0001);
        op = 4'h2; operand_a = 32'h1234_5678; operand_b = 32'h0;
        check("sub_ovf.res", result, 32'h7FFF_FFFF);
        check("sub_ovf.flags", {28'd0, zero_flag, neg_flag, carry_flag, ovf_flag}, 32'h1);
        tick();
        check("sub_ovf.hold", result, 32'h7FFF_FFFF);
        drain();

        run_sc("sub_borrow", 4'h1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0110);
        run_sc("sra", 4'h9, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0100);
        run_sc("srl", 4'h6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0000);
        run_sc("sll31", 4'h5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0100);
        run_sc("sll33", 4'h5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000);
        run_sc("xor", 4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
        run_sc("and", 4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        run_sc("or", 4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b0100);
        run_sc("slt", 4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000);
        run_sc("sltu", 4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000);
        run_sc("sgeu", 4'hC, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000);
        run_sc("eq", 4'hA, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 4'b0000);
        run_sc("ne", 4'hB, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'b1000);

        // MUL with latency check and 5 cycles of backpressure
        begin
            int lat;
            issue(4'hD, 32'h0001_0003, 32'h0000_0005);
            lat = 1;
            check("mul.busy", {31'd0, busy}, 32'd1);
            while (!out_valid && lat < 100) begin
                tick();
                lat++;
            end
            check("mul.lat", lat, 32'd33);
            for (int i = 0; i < 5; i++) begin
                check("mul.hold_res", result, 32'h0005_000F);
                check("mul.hold_valid", {31'd0, out_valid}, 32'd1);
                check("mul.hold_in_ready", {31'd0, in_ready}, 32'd0);
                tick();
            end
            check("mul.err", {31'd0, err}, 32'd0);
            check("mul.cf", {30'd0, carry_flag, ovf_flag}, 32'd0);
            drain();
            check("mul.released", {31'd0, out_valid}, 32'd0);
        end

        run_long("divu", 4'hE, 32'd100, 32'd7, 32'd14, 1'b0);
        run_long("remu", 4'hF, 32'd100, 32'd7, 32'd2, 1'b0);
        run_long("divu0", 4'hE, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_long("remu0", 4'hF, 32'd5, 32'd0, 32'd5, 1'b1);
        run_long("mul_big", 4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

        // 10 back-to-back ADDs, one result per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 4'h0;
        operand_b = 32'd100;
        for (int i = 0; i < 10; i++) begin
            operand_a = 32'(i * 3);
            check("b2b.in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("b2b.valid", {31'd0, out_valid}, 32'd1);
            check("b2b.res", result, 32'(i * 3 + 100));
        end
        in_valid = 1'b0;
        tick();
        check("b2b.idle", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a MUL
        issue(4'hD, 32'h0001_0003, 32'h0000_0005);
        repeat (9) tick();
        check("mid.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.valid", {31'd0, out_valid}, 32'd0);
        check("mid.busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid.in_ready", {31'd0, in_ready}, 32'd1);
        run_sc("post_rst_add", 4'h0, 32'd2, 32'd3, 32'd5, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
